// File: rtl/line_mem_pkg.sv
// Package line_mem_pkg: shared constants for the line RAM responder.
//   LINE_W / LINE_BYTES / OFFSET_W : geometry of one 128-bit line
//   state_t                         : responder FSM states (IDLE/WAIT/RESP)
//   LFSR_SEED / LFSR_TAPS           : latency-jitter LFSR (x^8+x^6+x^5+x^4+1)
//   lfsr_step()                     : one Fibonacci step of that LFSR
package line_mem_pkg;

    localparam int LINE_W     = 128;
    localparam int LINE_BYTES = LINE_W / 8;
    localparam int OFFSET_W   = $clog2(LINE_BYTES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        WAIT = ST_WAIT,
        RESP = ST_RESP
    } state_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Feedback taps at bits 7,5,4,3 realise x^8+x^6+x^5+x^4+1 for a left shift.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/line_ram_array.sv
// line_ram_array: storage for the line responder. Synchronous single-port
// RAM with a registered read port, shaped so it maps onto block RAM.
// Parameters:
//   DEPTH_LOG2 : number of lines = 2**DEPTH_LOG2
//   INIT_FILE  : preload image name; accepted for compatibility, no preload
// Ports:
//   clk : clock
//   we  : write enable, writes wd to line idx
//   idx : line index for both the write and the read
//   wd  : write data (one line)
//   rd  : registered read data, mem[idx] as sampled on the previous edge
module line_ram_array
    import line_mem_pkg::*;
#(
    parameter int    DEPTH_LOG2 = 10,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [LINE_W-1:0]     wd,
    output logic [LINE_W-1:0]     rd
);

    logic [LINE_W-1:0] mem_reg [2**DEPTH_LOG2];
    logic [LINE_W-1:0] rd_reg;

    // Read-first single port; the controller never reads the line it is
    // writing in the same cycle, so the ordering does not matter to it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[idx] <= wd;
        end
        rd_reg <= mem_reg[idx];
    end

    assign rd = rd_reg;

endmodule

// File: rtl/line_ram_responder.sv
// line_ram_responder: block-RAM stand-in for the 128-bit DRAM line path.
// Accepts one request at a time and completes it a fixed (or, with the
// LINE_RAM_JITTER_EN macro defined, LFSR-jittered) number of edges later.
// Parameters:
//   DEPTH_LOG2 : lines = 2**DEPTH_LOG2; addr index wraps (aliases) beyond it
//   LATENCY    : edges from accept to the edge that samples ready=1 (1..15)
//   INIT_FILE  : preload image name for the array (passed through)
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   valid : request present, held until valid&ready
//   ready : one-cycle completion pulse
//   addr  : byte address, line index = addr[4 +: DEPTH_LOG2]
//   wmask : 1 = write wdata, 0 = read
//   wdata : write line
//   rdata : read line; valid with ready, held until the next read completes
//   busy  : high from accept until the ready cycle ends
// Macro LINE_RAM_JITTER_EN: adds 0..7 extra edges per request from an
// 8-bit LFSR seeded with 8'hA5 and advanced once per accept.
module line_ram_responder
    import line_mem_pkg::*;
#(
    parameter int    DEPTH_LOG2 = 10,
    parameter int    LATENCY    = 4,
    parameter string INIT_FILE  = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    output logic              ready,
    input  logic [31:0]       addr,
    input  logic              wmask,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata,
    output logic              busy
);

`ifdef LINE_RAM_JITTER_EN
    localparam int CNT_W = 5;
`else
    localparam int CNT_W = 4;
`endif
    localparam logic [CNT_W-1:0] CNT_BASE = CNT_W'(LATENCY - 1);

    state_t                  state_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [DEPTH_LOG2-1:0]   idx_reg;
    logic                    wmask_reg;
    logic [LINE_W-1:0]       wdata_reg;
    logic                    ready_reg;
    logic                    busy_reg;
    logic [LINE_W-1:0]       rdata_hold_reg;

    logic [CNT_W-1:0]        cnt_init;
    logic                    enter_resp;
    logic [DEPTH_LOG2-1:0]   cur_idx;
    logic                    cur_wmask;
    logic [LINE_W-1:0]       cur_wdata;
    logic                    ram_we;
    logic [LINE_W-1:0]       ram_rd;

    // Only the line index matters; the offset and alias bits are dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:OFFSET_W+DEPTH_LOG2], addr[OFFSET_W-1:0]};

`ifdef LINE_RAM_JITTER_EN
    logic [7:0] lfsr_reg;
    assign cnt_init = CNT_BASE + {{(CNT_W-3){1'b0}}, lfsr_reg[2:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_reg <= LFSR_SEED;
        end else if (state_reg == IDLE && valid) begin
            lfsr_reg <= lfsr_step(lfsr_reg);
        end
    end
`else
    assign cnt_init = CNT_BASE;
`endif

    // While idle the RAM is steered straight from the request inputs so a
    // latency-1 request can write, or launch its read, on the accept edge.
    // Afterwards the captured copies keep the port stable.
    always_comb begin
        cur_idx    = idx_reg;
        cur_wmask  = wmask_reg;
        cur_wdata  = wdata_reg;
        enter_resp = 1'b0;
        case (state_reg)
            IDLE: begin
                cur_idx    = addr[OFFSET_W +: DEPTH_LOG2];
                cur_wmask  = wmask;
                cur_wdata  = wdata;
                enter_resp = valid && (cnt_init == '0);
            end
            WAIT:    enter_resp = (cnt_reg == CNT_W'(1));
            default: enter_resp = 1'b0;
        endcase
    end

    // The write lands on the edge entering RESP; a reset before then
    // returns the FSM to IDLE and the write never happens.
    assign ram_we = enter_resp && cur_wmask;

    line_ram_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .INIT_FILE  (INIT_FILE)
    ) u_array (
        .clk (clk),
        .we  (ram_we),
        .idx (cur_idx),
        .wd  (cur_wdata),
        .rd  (ram_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            idx_reg        <= '0;
            wmask_reg      <= 1'b0;
            wdata_reg      <= '0;
            ready_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            rdata_hold_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (valid) begin
                        idx_reg   <= addr[OFFSET_W +: DEPTH_LOG2];
                        wmask_reg <= wmask;
                        wdata_reg <= wdata;
                        cnt_reg   <= cnt_init;
                        busy_reg  <= 1'b1;
                        if (enter_resp) begin
                            state_reg <= RESP;
                            ready_reg <= 1'b1;
                        end else begin
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (enter_resp) begin
                        state_reg <= RESP;
                        ready_reg <= 1'b1;
                    end
                end
                RESP: begin
                    // valid is deliberately ignored here: no re-accept on
                    // the handshake edge.
                    state_reg <= IDLE;
                    ready_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    if (!wmask_reg) begin
                        rdata_hold_reg <= ram_rd;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // The RAM's own output register carries the read line during the ready
    // cycle; the hold register takes it over from the exit edge onward.
    assign ready = ready_reg;
    assign busy  = busy_reg;
    assign rdata = (ready_reg && !wmask_reg) ? ram_rd : rdata_hold_reg;

endmodule

// File: tb/tb_line_ram_responder.sv
module tb_line_ram_responder;

`ifdef LINE_RAM_JITTER_EN
    localparam int LAT  = 2;
    localparam int LMAX = LAT + 7;
`else
    localparam int LAT  = 4;
    localparam int LMAX = LAT;
`endif

    logic         clk;
    logic         rst;
    logic         valid;
    logic         ready;
    logic [31:0]  addr;
    logic         wmask;
    logic [127:0] wdata;
    logic [127:0] rdata;
    logic         busy;

    line_ram_responder #(
        .DEPTH_LOG2 (10),
        .LATENCY    (LAT),
        .INIT_FILE  ("")
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .valid (valid),
        .ready (ready),
        .addr  (addr),
        .wmask (wmask),
        .wdata (wdata),
        .rdata (rdata),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           w;
        int           idx;
        logic [127:0] d;
        int           acc;
        bit           first;
    } req_t;

    req_t         q[$];
    logic [127:0] mem_m [int];
    logic [31:0]  known[$];
    int           total = 0;
    int           bad = 0;
    int           edge_n = 0;
    int           done_edge = 0;
    int           hs = 0;
    bit           first_after_rst = 1'b1;
    logic [127:0] last_rd = '0;
    bit           rd_known = 1'b1;

    function automatic int idx_of(input logic [31:0] a);
        return int'(a[13:4]);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @edge %0d: got %h expected %h", name, edge_n, act, exp);
        end
    endtask

    // Reference: accept whenever valid is seen while the model is idle.
    always @(posedge clk) begin
        req_t e;
        edge_n++;
        if (!rst && valid && q.size() == 0 && edge_n > done_edge) begin
            e.w     = wmask;
            e.idx   = idx_of(addr);
            e.d     = wdata;
            e.acc   = edge_n;
            e.first = first_after_rst;
            first_after_rst = 1'b0;
            q.push_back(e);
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        req_t e;
        int   lat;
        logic [127:0] exp_d;
        if (rst) begin
            q.delete();
            last_rd         = '0;
            rd_known        = 1'b1;
            done_edge       = edge_n;
            first_after_rst = 1'b1;
            chk("rst_ready", {127'd0, ready}, 128'd0);
            chk("rst_busy",  {127'd0, busy},  128'd0);
            chk("rst_rdata", rdata, 128'd0);
        end else begin
            chk("busy", {127'd0, busy}, {127'd0, (q.size() > 0)});
            if (ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ready_unexpected @edge %0d: got ready=1 expected ready=0", edge_n);
                end else begin
                    e   = q.pop_front();
                    lat = edge_n - e.acc + 1;
`ifdef LINE_RAM_JITTER_EN
                    if (e.first) chk("latency_first", 128'(lat), 128'(LAT + 5));
                    else chk("latency_in_range", {127'd0, (lat >= LAT && lat <= LMAX)}, 128'd1);
`else
                    chk("latency", 128'(lat), 128'(LAT));
`endif
                    if (e.w) begin
                        mem_m[e.idx] = e.d;
                        if (rd_known) chk("rdata_kept_on_write", rdata, last_rd);
                    end else if (mem_m.exists(e.idx)) begin
                        exp_d = mem_m[e.idx];
                        chk("rdata", rdata, exp_d);
                        last_rd  = exp_d;
                        rd_known = 1'b1;
                    end else begin
                        rd_known = 1'b0;
                    end
                    done_edge = edge_n + 1;
                    hs++;
                end
            end else begin
                if (q.size() > 0 && (edge_n - q[0].acc + 1) >= LMAX) begin
                    total++;
                    bad++;
                    $display("FAIL ready_missing @edge %0d: got ready=0 expected ready=1 (accept edge %0d)",
                             edge_n, q[0].acc);
                    void'(q.pop_front());
                    done_edge = edge_n;
                end
                if (rd_known) chk("rdata_hold", rdata, last_rd);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents a request and returns #1 after its handshake edge with valid
    // still high; the caller decides whether to drop it.
    task automatic go(input bit w, input logic [31:0] a, input logic [127:0] d, input bit drop);
        int h0;
        int t;
        valid = 1'b1;
        wmask = w;
        addr  = a;
        wdata = d;
        h0 = hs;
        t  = 0;
        do begin
            @(posedge clk);
            t++;
            if (drop && t == 1) begin
                #1 valid = 1'b0;
            end
        end while (hs == h0 && t < 100);
        if (hs == h0) begin
            total++;
            bad++;
            $display("FAIL handshake_timeout: got no ready in %0d cycles expected one", t);
        end
        #1;
        $display("txn %s addr=%h data=%h", w ? "W" : "R", a, d);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [31:0]  ra;
        logic [127:0] d1;
        rst   = 1'b1;
        valid = 1'b0;
        wmask = 1'b0;
        addr  = '0;
        wdata = '0;
        tick(3);
        rst = 1'b0;

        // Idle after reset: outputs stay at zero.
        tick(20);

        // Write then read one line.
        go(1'b1, 32'h40, 128'h0123456789abcdefdeadbeefabad1dea, 1'b0);
        valid = 1'b0;
        tick(2);
        go(1'b0, 32'h40, '0, 1'b0);
        valid = 1'b0;
        tick(2);
        known.push_back(32'h40);

        // Back-to-back alternating write/read with aliased read addresses.
        for (int i = 0; i < 50; i++) begin
            ra = $urandom();
            go(1'b1, ra, rnd128(), 1'b0);
            known.push_back(ra);
            ra = known[$urandom_range(0, known.size() - 1)] ^ ($urandom() & 32'hFFFF_C00F);
            go(1'b0, ra, '0, 1'b0);
        end
        valid = 1'b0;
        tick(3);

        // Index aliasing at DEPTH_LOG2 = 10.
        go(1'b1, 32'h0000_0000, {16{8'hAA}}, 1'b0);
        go(1'b1, 32'h0000_4000, {16{8'h55}}, 1'b0);
        go(1'b0, 32'h0000_0000, '0, 1'b0);
        valid = 1'b0;
        tick(2);

        // valid dropped right after accept: the request still completes.
        go(1'b0, 32'h40, '0, 1'b1);
        valid = 1'b0;
        tick(2);

        // Reset during the wait of a write: the write is discarded.
        d1 = rnd128();
        go(1'b1, 32'h80, d1, 1'b0);
        valid = 1'b0;
        tick(2);
        valid = 1'b1;
        wmask = 1'b1;
        addr  = 32'h80;
        wdata = ~d1;
        tick(2);
        rst   = 1'b1;
        valid = 1'b0;
        tick(4);
        rst = 1'b0;
        tick(2);
        go(1'b0, 32'h80, '0, 1'b0);
        valid = 1'b0;
        tick(3);

`ifdef LINE_RAM_JITTER_EN
        // Jittered latency: first request after reset uses the seed.
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        for (int i = 0; i < 1000; i++) begin
            go(1'b0, 32'h40, '0, 1'b0);
        end
        valid = 1'b0;
        tick(3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
